stream_overflow_mon: RTL and testbench

STREAM_OVERFLOW_MON -- requirements
Module: stream_overflow_mon

---
 rtl/stream_overflow_mon_pkg.sv | 14 +
 rtl/stream_overflow_chan.sv | 60 ++++++
 rtl/stream_overflow_mon.sv | 124 ++++++++++++
 tb/tb_stream_overflow_mon.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_overflow_mon_pkg.sv
// Shared sizing helpers for the stream overflow monitor and its per-channel slice.
package stream_overflow_mon_pkg;

  // Channel-index width: at least one bit, even for a single monitored stream.
  function automatic int chw_f(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Run-counter width: must hold values 0..GRACE+1 inclusive.
  function automatic int runw_f(input int grace);
    return $clog2(grace + 2);
  endfunction

endpackage

// File: rtl/stream_overflow_chan.sv
// One monitored stream: consecutive-stall run counter, sticky overflow flag and
// saturating stall counter. The qualify output marks the cycle that trips the flag.
module stream_overflow_chan
  import stream_overflow_mon_pkg::*;
#(
  parameter int CW    = 32,
  parameter int GRACE = 0
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  input  logic          viol,
  output logic          qualify,
  output logic          overflow,
  output logic [CW-1:0] stall_count
);

  localparam int            RW       = runw_f(GRACE);
  localparam logic [RW-1:0] RunGrace = RW'(GRACE);
  localparam logic [RW-1:0] RunMax   = RW'(GRACE + 1);

  logic [RW-1:0] run_q, run_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign qualify     = viol && (run_q == RunGrace);
  assign overflow    = ovf_q;
  assign stall_count = cnt_q;

  // The run counter parks at GRACE+1 so a long stall can never re-qualify.
  always_comb begin
    run_d = run_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (clear) begin
      run_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (viol) begin
      if (run_q != RunMax) run_d = run_q + 1'b1;
      if (qualify)         ovf_d = 1'b1;
      if (cnt_q != '1)     cnt_d = cnt_q + 1'b1;
    end else begin
      run_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stream_overflow_mon.sv
// Passive AXI-Stream backpressure monitor: per-channel overflow flags and stall
// counts, a free-running timestamp and a first-offender capture record.
module stream_overflow_mon
  import stream_overflow_mon_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DW    = 512,
  parameter int CW    = 32,
  parameter int GRACE = 0,
  localparam int CHW  = chw_f(NCH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic              clear,
  input  logic [NCH-1:0]    stream_tvalid,
  input  logic [NCH-1:0]    stream_tready,
  input  logic [NCH*DW-1:0] stream_tdata,
  output logic [NCH-1:0]    overflow,
  output logic              any_overflow,
  output logic              irq,
  output logic              first_valid,
  output logic [CHW-1:0]    first_ch,
  output logic [CW-1:0]     first_time,
  output logic [DW-1:0]     first_tdata,
  output logic [NCH*CW-1:0] stall_count
);

  logic [NCH-1:0] viol;
  logic [NCH-1:0] qual;

  logic [CW-1:0]  ts_q, ts_d;
  logic           fv_q, fv_d;
  logic [CHW-1:0] fch_q, fch_d;
  logic [CW-1:0]  ftime_q, ftime_d;
  logic [DW-1:0]  fdata_q, fdata_d;
  logic           irq_q, irq_d;

  logic           win_found;
  logic [CHW-1:0] win_ch;
  logic [DW-1:0]  win_data;

  assign viol = {NCH{enable}} & stream_tvalid & ~stream_tready;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    stream_overflow_chan #(
      .CW    (CW),
      .GRACE (GRACE)
    ) u_chan (
      .clk         (clk),
      .resetn      (resetn),
      .clear       (clear),
      .viol        (viol[i]),
      .qualify     (qual[i]),
      .overflow    (overflow[i]),
      .stall_count (stall_count[i*CW +: CW])
    );
  end

  assign any_overflow = |overflow;
  assign irq          = irq_q;
  assign first_valid  = fv_q;
  assign first_ch     = fch_q;
  assign first_time   = ftime_q;
  assign first_tdata  = fdata_q;

  // Scanning downward leaves the lowest qualifying channel as the winner.
  always_comb begin
    win_found = 1'b0;
    win_ch    = '0;
    win_data  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (qual[i]) begin
        win_found = 1'b1;
        win_ch    = CHW'(i);
        win_data  = stream_tdata[i*DW +: DW];
      end
    end
  end

  // Clear wins over any same-cycle event; irq fires on the edge overflow first rises.
  always_comb begin
    ts_d    = ts_q + 1'b1;
    fv_d    = fv_q;
    fch_d   = fch_q;
    ftime_d = ftime_q;
    fdata_d = fdata_q;
    irq_d   = 1'b0;
    if (clear) begin
      ts_d    = '0;
      fv_d    = 1'b0;
      fch_d   = '0;
      ftime_d = '0;
      fdata_d = '0;
    end else begin
      irq_d = win_found && !any_overflow;
      if (!fv_q && win_found) begin
        fv_d    = 1'b1;
        fch_d   = win_ch;
        ftime_d = ts_q;
        fdata_d = win_data;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ts_q    <= '0;
      fv_q    <= 1'b0;
      fch_q   <= '0;
      ftime_q <= '0;
      fdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      ts_q    <= ts_d;
      fv_q    <= fv_d;
      fch_q   <= fch_d;
      ftime_q <= ftime_d;
      fdata_q <= fdata_d;
      irq_q   <= irq_d;
    end
  end

endmodule

// File: tb/tb_stream_overflow_mon.sv
// Bench for stream_overflow_mon: two instances (GRACE=0/CW=8 and GRACE=3/CW=4)
// share stimulus and are scored against a cycle-level behavioural model.
module tb_stream_overflow_mon;

  localparam int NCH = 4;
  localparam int DW  = 16;

  logic              clk;
  logic              resetn;
  logic              enable;
  logic              clear;
  logic [NCH-1:0]    tvalid;
  logic [NCH-1:0]    tready;
  logic [NCH*DW-1:0] tdata;

  logic [3:0]  ovf0, ovf3;
  logic        any0, any3, irq0, irq3, fv0, fv3;
  logic [1:0]  fch0, fch3;
  logic [7:0]  ft0;
  logic [3:0]  ft3;
  logic [15:0] fd0, fd3;
  logic [31:0] sc0;
  logic [15:0] sc3;

  stream_overflow_mon #(.NCH(NCH), .DW(DW), .CW(8), .GRACE(0)) dut0 (
    .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
    .stream_tvalid(tvalid), .stream_tready(tready), .stream_tdata(tdata),
    .overflow(ovf0), .any_overflow(any0), .irq(irq0), .first_valid(fv0),
    .first_ch(fch0), .first_time(ft0), .first_tdata(fd0), .stall_count(sc0)
  );

  stream_overflow_mon #(.NCH(NCH), .DW(DW), .CW(4), .GRACE(3)) dut3 (
    .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
    .stream_tvalid(tvalid), .stream_tready(tready), .stream_tdata(tdata),
    .overflow(ovf3), .any_overflow(any3), .irq(irq3), .first_valid(fv3),
    .first_ch(fch3), .first_time(ft3), .first_tdata(fd3), .stall_count(sc3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nAssert = 0;
  int nFail   = 0;

  int gracePar[2] = '{0, 3};
  int cwPar[2]    = '{8, 4};
  int mRun[2][NCH];
  bit mOvf[2][NCH];
  int mStall[2][NCH];
  int mTs[2];
  bit mFv[2];
  int mFch[2];
  int mFtime[2];
  int mFdata[2];
  bit mIrq[2];

  typedef struct {
    bit         en;
    bit         clr;
    logic [3:0] tv;
    logic [3:0] tr;
    logic [3:0] expOvf;
    bit         expIrq;
  } vec_t;

  vec_t tbl[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    nAssert++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NCH; c++) begin
        mRun[k][c] = 0; mOvf[k][c] = 0; mStall[k][c] = 0;
      end
      mTs[k] = 0; mFv[k] = 0; mFch[k] = 0; mFtime[k] = 0; mFdata[k] = 0; mIrq[k] = 0;
    end
  endtask

  // One clock of the reference: the (GRACE+1)-th consecutive stall cycle trips the flag.
  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      int maxv = (1 << cwPar[k]) - 1;
      bit anyBefore = 0;
      bit anyAfter = 0;
      int firstQ = -1;
      for (int c = 0; c < NCH; c++) anyBefore |= mOvf[k][c];
      if (clear) begin
        for (int c = 0; c < NCH; c++) begin
          mRun[k][c] = 0; mOvf[k][c] = 0; mStall[k][c] = 0;
        end
        mTs[k] = 0; mFv[k] = 0; mFch[k] = 0; mFtime[k] = 0; mFdata[k] = 0; mIrq[k] = 0;
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (enable && tvalid[c] && !tready[c]) begin
            if (mRun[k][c] == gracePar[k]) begin
              mOvf[k][c] = 1;
              if (firstQ < 0) firstQ = c;
            end
            mRun[k][c]++;
            if (mStall[k][c] < maxv) mStall[k][c]++;
          end else begin
            mRun[k][c] = 0;
          end
          anyAfter |= mOvf[k][c];
        end
        if (!mFv[k] && firstQ >= 0) begin
          mFv[k]    = 1;
          mFch[k]   = firstQ;
          mFtime[k] = mTs[k];
          mFdata[k] = int'(tdata[firstQ*DW +: DW]);
        end
        mIrq[k] = anyAfter && !anyBefore;
        mTs[k]  = (mTs[k] + 1) & maxv;
      end
    end
  endtask

  task automatic checkInst(input int k, input logic [3:0] ovf, input logic anyo,
                           input logic irq, input logic fv, input logic [1:0] fch,
                           input int ftime, input logic [15:0] fdata, input logic [31:0] sc);
    int expOvf = 0;
    int maxv = (1 << cwPar[k]) - 1;
    for (int c = 0; c < NCH; c++) expOvf |= int'(mOvf[k][c]) << c;
    checkOutput($sformatf("inst%0d overflow", k), int'(ovf), expOvf);
    checkOutput($sformatf("inst%0d any_overflow", k), int'(anyo), int'(expOvf != 0));
    checkOutput($sformatf("inst%0d irq", k), int'(irq), int'(mIrq[k]));
    checkOutput($sformatf("inst%0d first_valid", k), int'(fv), int'(mFv[k]));
    checkOutput($sformatf("inst%0d first_ch", k), int'(fch), mFch[k]);
    checkOutput($sformatf("inst%0d first_time", k), ftime, mFtime[k]);
    checkOutput($sformatf("inst%0d first_tdata", k), int'(fdata), mFdata[k]);
    for (int c = 0; c < NCH; c++)
      checkOutput($sformatf("inst%0d stall_count[%0d]", k, c),
                  int'(sc >> (c * cwPar[k])) & maxv, mStall[k][c]);
  endtask

  task automatic checkAll();
    checkInst(0, ovf0, any0, irq0, fv0, fch0, int'(ft0), fd0, sc0);
    checkInst(1, ovf3, any3, irq3, fv3, fch3, int'(ft3), fd3, {16'h0, sc3});
  endtask

  task automatic applyStimulus(input bit en, input bit clr, input logic [3:0] tv,
                               input logic [3:0] tr, input logic [NCH*DW-1:0] data);
    enable = en; clear = clr; tvalid = tv; tready = tr; tdata = data;
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic resetPulse();
    resetn = 1'b0;
    #1;
    modelReset();
    checkAll();
    checkOutput("async reset any_overflow", int'(any0), 0);
    checkOutput("async reset stall_count", int'(sc0), 0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  localparam logic [NCH*DW-1:0] FixedData = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

  initial begin
    resetn = 1'b0; enable = 1'b0; clear = 1'b0;
    tvalid = '0; tready = '0; tdata = '0;
    modelReset();
    #2;
    checkAll();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) tbl.push_back('{1, 0, 4'b0000, 4'b0000, 4'b0000, 0});
    tbl.push_back('{1, 0, 4'b0100, 4'b0000, 4'b0100, 1});
    tbl.push_back('{1, 0, 4'b0000, 4'b0000, 4'b0100, 0});
    tbl.push_back('{1, 1, 4'b0000, 4'b0000, 4'b0000, 0});
    tbl.push_back('{1, 0, 4'b1010, 4'b0000, 4'b1010, 1});
    tbl.push_back('{1, 0, 4'b0000, 4'b0000, 4'b1010, 0});
    tbl.push_back('{1, 1, 4'b0001, 4'b0000, 4'b0000, 0});
    tbl.push_back('{1, 0, 4'b0000, 4'b0000, 4'b0000, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].en, tbl[i].clr, tbl[i].tv, tbl[i].tr, FixedData);
      checkOutput($sformatf("table row %0d overflow", i), int'(ovf0), int'(tbl[i].expOvf));
      checkOutput($sformatf("table row %0d irq", i), int'(irq0), int'(tbl[i].expIrq));
      if (i == 11) begin
        checkOutput("ch2 first_ch", int'(fch0), 2);
        checkOutput("ch2 first_time", int'(ft0), 10);
        checkOutput("ch2 first_tdata", int'(fd0), 16'hA002);
        checkOutput("ch2 stall_count", int'(sc0[23:16]), 1);
      end
      if (i == 14) checkOutput("simultaneous first_ch", int'(fch0), 1);
      if (i == 15) begin
        checkOutput("clear first_valid", int'(fv0), 0);
        checkOutput("clear stall_count", int'(sc0), 0);
      end
    end

    // Grace window: three stalls tolerated, the fourth trips the flag.
    applyStimulus(1, 1, 4'b0000, 4'b0000, FixedData);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 4'b0001, 4'b0000, FixedData);
    applyStimulus(1, 0, 4'b0001, 4'b0001, FixedData);
    checkOutput("grace3 three stalls overflow", int'(ovf3), 0);
    checkOutput("grace3 three stalls count", int'(sc3[3:0]), 3);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 4'b0001, 4'b0000, FixedData);
    checkOutput("grace3 four stalls overflow", int'(ovf3[0]), 1);

    // Saturation and timestamp wrap on the CW=4 instance.
    applyStimulus(1, 1, 4'b0000, 4'b0000, FixedData);
    for (int i = 0; i < 14; i++) applyStimulus(1, 0, 4'b0000, 4'b0000, FixedData);
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 4'b0001, 4'b0000, FixedData);
    checkOutput("cw4 saturated stall_count", int'(sc3[3:0]), 15);
    checkOutput("cw4 wrapped first_time", int'(ft3), 1);
    checkOutput("cw8 stall_count", int'(sc0[7:0]), 20);
    checkOutput("cw8 first_time", int'(ft0), 14);

    // Disabled monitoring, then a reset that lands in the middle of a stall.
    applyStimulus(1, 1, 4'b0000, 4'b0000, FixedData);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 4'b0001, 4'b0000, FixedData);
    checkOutput("disabled overflow", int'(ovf0), 0);
    checkOutput("disabled stall_count", int'(sc0), 0);
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 4'b0001, 4'b0000, FixedData);
    resetPulse();
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 4'b0001, 4'b0000, FixedData);
    checkOutput("post-reset grace3 overflow", int'(ovf3), 0);

    for (int i = 0; i < 600; i++) begin
      logic [3:0] tv;
      logic [3:0] tr;
      tv = 4'($urandom);
      tr = ((i / 50) % 2 == 0) ? 4'($urandom) & 4'($urandom) : 4'($urandom) | 4'($urandom);
      applyStimulus(($urandom % 8) != 0, ($urandom % 60) == 0, tv, tr,
                    {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
